// File: rtl/store_data_aligner.sv
// store_data_aligner: rotates an LSB-justified store payload into 128-bit line lanes with byte strobes, splitting line-crossing stores into two beats.
// Optional: define STORE_ALIGN_SPLIT_CNT_EN for a saturating split-request counter (split_cnt, split_cnt_clr).
module store_data_aligner #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
`ifdef STORE_ALIGN_SPLIT_CNT_EN
  input  logic              split_cnt_clr,
  output logic [15:0]       split_cnt,
`endif
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [4:0]        in_len,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_strb,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state, state_d;
  logic [3:0] off;
  logic [4:0] lc;
  logic [15:0] m, mask, hi, strb1_q;
  logic [DATA_W-1:0] rot;
  logic split, load, hs;
  always_comb begin
    off = in_addr[3:0];
    lc = (in_len > 5'd16) ? 5'd16 : in_len;
    m = lc[4] ? 16'hffff : (16'h1 << lc[3:0]) - 16'h1;
    mask = (m << off) | (m >> (5'd16 - {1'b0, off}));
    hi = 16'hffff << off;
    rot = (in_data << {off, 3'b0}) | (in_data >> (8'd128 - {1'b0, off, 3'b0}));
    split = ({1'b0, off} + lc) > 5'd16;
    out_vld = state != IDLE;
    in_rdy = ~out_vld | (out_rdy & out_last);
    load = in_vld & in_rdy & (in_len != 5'd0);
    hs = out_vld & out_rdy;
    state_d = load ? BEAT0 : hs ? ((state == BEAT0 && !out_last) ? BEAT1 : IDLE) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  // Beat1 reuses the registered rotated data; only address, strobes and last change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr <= '0;
      out_data <= '0;
      out_strb <= '0;
      out_last <= 1'b0;
      strb1_q <= '0;
    end else if (load) begin
      out_addr <= {in_addr[ADDR_W-1:4], 4'b0};
      out_data <= rot;
      out_strb <= split ? (mask & hi) : mask;
      strb1_q <= mask & ~hi;
      out_last <= ~split;
    end else if (hs && state == BEAT0 && !out_last) begin
      out_addr <= out_addr + ADDR_W'(16);
      out_strb <= strb1_q;
      out_last <= 1'b1;
    end
  end
`ifdef STORE_ALIGN_SPLIT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) split_cnt <= '0;
    else if (split_cnt_clr) split_cnt <= '0;
    else if (load && split && split_cnt != 16'hffff) split_cnt <= split_cnt + 16'h1;
  end
`endif
endmodule

// File: tb/tb_store_data_aligner.sv
// tb_store_data_aligner: directed self-checking bench for store_data_aligner.
module tb_store_data_aligner;
  logic clk = 0, rst = 1;
  logic in_vld = 0, in_rdy, out_vld, out_rdy = 1, out_last;
  logic [31:0] in_addr = 0, out_addr;
  logic [4:0] in_len = 0;
  logic [127:0] in_data = 0, out_data;
  logic [15:0] out_strb;
  int errs = 0, checks = 0;
`ifdef STORE_ALIGN_SPLIT_CNT_EN
  logic split_cnt_clr = 0;
  logic [15:0] split_cnt;
`endif
  store_data_aligner dut (
    .clk(clk), .rst(rst),
`ifdef STORE_ALIGN_SPLIT_CNT_EN
    .split_cnt_clr(split_cnt_clr), .split_cnt(split_cnt),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_len(in_len), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_data(out_data),
    .out_strb(out_strb), .out_last(out_last)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [4:0] l, input logic [127:0] d);
    for (int i = 0; i < 20 && !in_rdy; i++) tick();
    check("send_rdy", in_rdy, 1'b1);
    in_vld = 1; in_addr = a; in_len = l; in_data = d;
    tick();
    in_vld = 0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [127:0] d,
                      input logic [15:0] s, input logic l);
    check({tag, "_vld"}, out_vld, 1'b1);
    check({tag, "_addr"}, out_addr, a);
    check({tag, "_data"}, out_data, d);
    check({tag, "_strb"}, out_strb, s);
    check({tag, "_last"}, out_last, l);
  endtask

  initial begin
    logic [127:0] seq;
    for (int i = 0; i < 16; i++) seq[8*i +: 8] = 8'(i);
    #2;
    check("rst_vld", out_vld, 1'b0);
    check("rst_data", out_data, 128'h0);
    check("rst_strb", out_strb, 16'h0);
    check("rst_addr", out_addr, 32'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_rdy", in_rdy, 1'b1);
    tick();
    rst = 0;
    tick();
`ifdef STORE_ALIGN_SPLIT_CNT_EN
    check("cnt_rst", split_cnt, 16'h0);
`endif
    // aligned full line
    send(32'h1000, 5'd16, seq);
    beat("full", 32'h1000, seq, 16'hffff, 1'b1);
    tick();
    check("full_idle", out_vld, 1'b0);
    // unaligned, no split, one-cycle latency
    send(32'h1004, 5'd4, 128'hDDCCBBAA);
    beat("unal", 32'h1000, 128'hDDCCBBAA_00000000, 16'h00f0, 1'b1);
    tick();
    // split with backpressure on beat0
    send(32'h100E, 5'd4, 128'h44332211);
    out_rdy = 0;
    beat("sp0", 32'h1000, 128'h2211_0000_0000_0000_0000_0000_0000_4433, 16'hc000, 1'b0);
    check("sp0_rdy", in_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("stall", 32'h1000, 128'h2211_0000_0000_0000_0000_0000_0000_4433, 16'hc000, 1'b0);
      check("stall_rdy", in_rdy, 1'b0);
    end
    out_rdy = 1;
    check("sp0_rdy_open", in_rdy, 1'b0);
    tick();
    beat("sp1", 32'h1010, 128'h2211_0000_0000_0000_0000_0000_0000_4433, 16'h0003, 1'b1);
    check("sp1_rdy", in_rdy, 1'b1);
    tick();
    check("sp_idle", out_vld, 1'b0);
`ifdef STORE_ALIGN_SPLIT_CNT_EN
    check("cnt_one", split_cnt, 16'h1);
`endif
    // back-to-back stream, one beat per cycle
    for (int i = 0; i < 4; i++) begin
      check("b2b_rdy", in_rdy, 1'b1);
      in_vld = 1; in_addr = 32'h2000 + 32'(16 * i); in_len = 5'(i + 1); in_data = 128'(i + 1);
      tick();
      beat("b2b", 32'h2000 + 32'(16 * i), 128'(i + 1), 16'((1 << (i + 1)) - 1), 1'b1);
    end
    in_vld = 0;
    tick();
    check("b2b_idle", out_vld, 1'b0);
    // address wrap on beat1
    send(32'hFFFFFFF8, 5'd16, seq);
    beat("wr0", 32'hFFFFFFF0, 128'h07060504030201000F0E0D0C0B0A0908, 16'hff00, 1'b0);
    tick();
    beat("wr1", 32'h00000000, 128'h07060504030201000F0E0D0C0B0A0908, 16'h00ff, 1'b1);
    tick();
    // zero length is discarded
    send(32'h3004, 5'd0, 128'h55);
    check("l0_vld", out_vld, 1'b0);
    check("l0_rdy", in_rdy, 1'b1);
    // over-length clipped to 16
    send(32'h3000, 5'd20, seq);
    beat("clip", 32'h3000, seq, 16'hffff, 1'b1);
    tick();
    // async reset between beat0 and beat1
    send(32'h100E, 5'd4, 128'h44332211);
    out_rdy = 0;
    check("ar_pre", out_vld, 1'b1);
`ifdef STORE_ALIGN_SPLIT_CNT_EN
    check("cnt_three", split_cnt, 16'h3);
`endif
    rst = 1;
    #1;
    check("ar_vld", out_vld, 1'b0);
    check("ar_strb", out_strb, 16'h0);
`ifdef STORE_ALIGN_SPLIT_CNT_EN
    check("cnt_ar", split_cnt, 16'h0);
`endif
    tick();
    rst = 0;
    out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_nobeat", out_vld, 1'b0);
    end
`ifdef STORE_ALIGN_SPLIT_CNT_EN
    send(32'h400F, 5'd2, 128'hBEEF);
    tick();
    tick();
    check("cnt_inc", split_cnt, 16'h1);
    split_cnt_clr = 1;
    send(32'h400F, 5'd2, 128'hBEEF);
    split_cnt_clr = 0;
    check("cnt_clr", split_cnt, 16'h0);
    tick();
    tick();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/store_data_aligner.md
Name: store_data_aligner

Overview:
- Write-side counterpart of the load-path byte rotator.
- Accepts an LSB-justified store payload of 1..16 bytes plus a byte address.
- Rotates the payload into its 128-bit line lanes and produces byte strobes.
- Splits line-crossing stores into two line-aligned write beats over a valid/ready interface to the memory/buffer write port.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 128, line width in bits; fixed at 128, 16 byte lanes.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  request valid.
- in_rdy  output  1  request accepted when in_vld & in_rdy.
- in_addr  input  ADDR_W  byte address of payload byte 0.
- in_len  input  5  byte count; 1..16 legal.
- in_data  input  128  payload; byte k in bits [8k+7:8k].
- out_vld  output  1  write beat valid.
- out_rdy  input  1  downstream accepts beat.
- out_addr  output  ADDR_W  line address; bits [3:0] always 0.
- out_data  output  128  lane-aligned data.
- out_strb  output  16  byte enables, bit j = lane j.
- out_last  output  1  final beat of the request.

Behaviour:
- Reset (async, immediate): out_vld=0, out_data=0, out_strb=0, out_addr=0, out_last=0, state IDLE. Any pending second beat is dropped.
- Let off=in_addr[3:0] and L=in_len.
- L>16 is clipped to 16.
- L=0 is accepted and discarded: no beat, in_rdy unaffected.
- Rotation: payload byte k goes to lane (off+k) mod 16, i.e. a left rotate by off bytes. Rotated data is registered once and shared by both beats.
- Strobe mask: lanes off..off+L-1, taken mod 16.
- Non-split case (off+L<=16): one beat.
  - out_addr = {in_addr[ADDR_W-1:4],4'b0}.
  - strb = mask.
  - out_last=1.
- Split case (off+L>16): two beats.
  - Beat0: line address as above, strb lanes off..15, out_last=0.
  - Beat1: out_addr = beat0 address + 16, wrapping modulo 2^ADDR_W; strb lanes 0..off+L-17; out_last=1.
- States:
  - IDLE: out_vld=0.
  - BEAT0: presenting the first or only beat.
  - BEAT1: presenting the second beat of a split.
- Transitions:
  - IDLE -> BEAT0 on accept with L!=0.
  - BEAT0 -> BEAT1 on handshake if split.
  - BEAT0 -> BEAT0 on handshake if not split and a new request is accepted in the same cycle.
  - BEAT0 -> IDLE on handshake if not split and no new request.
  - BEAT1 -> BEAT0 or IDLE on handshake, by the same accept rule.
- in_rdy = ~out_vld | (out_rdy & out_last). Combinational from state and out_rdy; no combinational path from in_vld.
- Latency: a request accepted in cycle N has beat0 valid in N+1. Beat1 is valid in the cycle after the beat0 handshake.
- Throughput: 1 non-split request per cycle; a split request occupies 2 beat cycles.
- Stall: while out_vld & ~out_rdy, all out_* are held stable and in_rdy=0.
- Request fields are sampled only on accept. Input changes while in_rdy=0 have no effect.

Optional Feature:
- Macro: STORE_ALIGN_SPLIT_CNT_EN.
- When defined:
  - Adds output split_cnt[15:0], a saturating count of accepted split requests (holds at 0xFFFF).
  - Adds input split_cnt_clr; a synchronous clear that has priority over an increment in the same cycle.
  - Reset value is 0.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Aligned full line: addr=0x1000, L=16, data=0x0F0E..00 -> one beat, out_addr=0x1000, data unchanged, strb=0xFFFF, last=1.
- Unaligned, no split: addr=0x1004, L=4, data bytes AA,BB,CC,DD -> lanes 4..7 hold AA..DD, strb=0x00F0, last=1, latency 1 cycle.
- Split: addr=0x100E, L=4, bytes 11,22,33,44.
  - Beat0: addr 0x1000, lanes 14/15 = 11/22, strb=0xC000, last=0.
  - Beat1: addr 0x1010, lanes 0/1 = 33/44, strb=0x0003, last=1.
- Backpressure plus back-to-back: hold out_rdy=0 for 3 cycles during beat0 -> outputs stable, in_rdy=0. Then stream 4 non-split requests with out_rdy=1 -> one beat per cycle, no bubbles.
- Boundary: addr=0xFFFFFFF8, L=16 -> beat1 out_addr=0x00000000 (wrap), strb=0x00FF. L=0 request -> no beat emitted.
- Async reset asserted between beat0 and beat1 handshakes -> out_vld drops immediately, beat1 never appears. With STORE_ALIGN_SPLIT_CNT_EN defined, split_cnt reads 0 after reset and increments once per split.
